im_loader: RTL

Boot-time program loader and instruction-memory port arbiter for the 8-bit CPU. It receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words (high byte first), and writes them into the instruction memory from address 0 upward. While loading, it owns the instruction-memory address/write port and stalls the CPU. When idle, it passes the CPU program counter straight through to the instruction-memory address.

---
 rtl/im_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// Boot-time program loader: assembles a byte stream into 16-bit words and writes
// them to instruction memory from address 0, owning the IM port while loading.
module im_loader #(
    parameter int IM_DEPTH = 256,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic [7:0]  cpu_pc,
    output logic [7:0]  im_addr,
    output logic [15:0] im_wdata,
    output logic        im_we,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    n_q, n_d;
    logic [7:0]    waddr_q, waddr_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    lo_q, lo_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          in_rx;
    logic          accept;

    assign in_rx  = (state_q == S_LEN) || (state_q == S_HI) || (state_q == S_LO);
    assign accept = in_rx && s_valid;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        waddr_d = waddr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    // A count byte of zero stands for a full 256-word image
                    n_d     = (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
                    waddr_d = 8'd0;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = s_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    lo_d    = s_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if ({1'b0, waddr_q} == n_q - 9'd1) begin
                    state_d = S_DONE;
                end else begin
                    waddr_d = waddr_q + 8'd1;
                    state_d = S_HI;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog: only counts while waiting for stream data
        if (in_rx) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            waddr_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            waddr_q <= waddr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign s_ready   = in_rx;
    assign busy      = (state_q != S_IDLE);
    assign cpu_stall = busy;
    assign done      = (state_q == S_DONE);
    // Words beyond the memory depth are consumed but never written
    assign im_we     = (state_q == S_WRITE) && (int'(waddr_q) < IM_DEPTH);
    assign im_addr   = busy ? waddr_q : cpu_pc;
    assign im_wdata  = {hi_q, lo_q};
    assign err       = err_q;

endmodule
